// File: rtl/mult_share_sched_if.sv
// Request/response handshake bundle for the two requesters sharing one multiplier.
// The slave modport is the scheduler's view; master is the requesters' view.
interface mult_share_sched_if;
   logic       req0_valid;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic       req0_ready;
   logic       req1_valid;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic       req1_ready;
   logic       rsp0_valid;
   logic [7:0] rsp0_p;
   logic       rsp0_ready;
   logic       rsp1_valid;
   logic [7:0] rsp1_p;
   logic       rsp1_ready;

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready, rsp0_valid, rsp0_p, rsp1_valid, rsp1_p
   );

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready, rsp0_valid, rsp0_p, rsp1_valid, rsp1_p
   );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one 4x4 unsigned multiplier between two requesters.
// One operation in flight: accept, wait LAT cycles for the product, then hold the response.
module mult_share_sched #(
   parameter int LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   mult_share_sched_if.slave          bus,
   output logic [3:0]                 mul_a,
   output logic [3:0]                 mul_b,
   input  logic [7:0]                 mul_p,
   output logic                       busy,
   output logic [7:0]                 done_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       owner;
   logic       last_gnt;
   logic       gnt;
   logic [2:0] cnt;
   logic [7:0] res;
   logic       accept;
   logic       rsp_hs;

   always_comb begin
      state_nxt = state;
      // Tie goes to the requester not served last; with no requests the pointer still picks one.
      if (bus.req0_valid && bus.req1_valid) gnt = ~last_gnt;
      else if (bus.req1_valid)              gnt = 1'b1;
      else if (bus.req0_valid)              gnt = 1'b0;
      else                                  gnt = ~last_gnt;

      accept = (state == IDLE) && !rst &&
               (gnt ? bus.req1_valid : bus.req0_valid);
      rsp_hs = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);

      case (state)
         IDLE:    if (accept) state_nxt = WAIT;
         WAIT:    if (cnt == 3'd1) state_nxt = RESP;
         RESP:    if (rsp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.req0_ready = (state == IDLE) && !gnt && !rst;
   assign bus.req1_ready = (state == IDLE) &&  gnt && !rst;
   assign bus.rsp0_valid = (state == RESP) && !owner && !rst;
   assign bus.rsp1_valid = (state == RESP) &&  owner && !rst;
   assign bus.rsp0_p     = res;
   assign bus.rsp1_p     = res;
   assign busy           = (state != IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last_gnt <= 1'b1;
         cnt      <= 3'd0;
         mul_a    <= 4'd0;
         mul_b    <= 4'd0;
         res      <= 8'd0;
         done_cnt <= 8'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            mul_a    <= gnt ? bus.req1_a : bus.req0_a;
            mul_b    <= gnt ? bus.req1_b : bus.req0_b;
            owner    <= gnt;
            last_gnt <= gnt;
            cnt      <= 3'(LAT);
         end
         // Product is sampled in the last WAIT cycle, LAT cycles after the operands launched.
         if (state == WAIT) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) res <= mul_p;
         end
         if (rsp_hs) done_cnt <= done_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: LAT=1 instance with a combinational multiplier and
// LAT=3 instance with a multiplier that shows garbage except in the sampling cycle.
module tb_mult_share_sched;
   localparam int LAT1 = 1;
   localparam int LAT3 = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] mul_a1, mul_b1, mul_a3, mul_b3;
   logic [7:0] mul_p1, mul_p3, prod3, g3;
   logic       busy1, busy3;
   logic [7:0] done1, done3;
   int         k3;

   int   n_vec = 0;
   int   n_err = 0;
   bit   m_last;
   int   m_done;

   mult_share_sched_if if1 ();
   mult_share_sched_if if3 ();

   mult_share_sched #(.LAT(LAT1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave), .mul_a(mul_a1), .mul_b(mul_b1),
      .mul_p(mul_p1), .busy(busy1), .done_cnt(done1)
   );

   mult_share_sched #(.LAT(LAT3)) dut3 (
      .clk(clk), .rst(rst), .bus(if3.slave), .mul_a(mul_a3), .mul_b(mul_b3),
      .mul_p(mul_p3), .busy(busy3), .done_cnt(done3)
   );

   always #5 clk = ~clk;

   assign mul_p1 = mul_a1 * mul_b1;
   assign prod3  = mul_a3 * mul_b3;
   // Only the cycle LAT after acceptance carries the true product; every other cycle is wrong.
   assign mul_p3 = (k3 == LAT3) ? prod3 : prod3 + g3;

   always @(posedge clk) begin
      g3 <= 8'($urandom_range(1, 200));
      if ((if3.req0_valid && if3.req0_ready) || (if3.req1_valid && if3.req1_ready)) k3 <= 1;
      else if (k3 != 0 && k3 < 100) k3 <= k3 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic rsp_v(input bit n);
      return n ? if1.rsp1_valid : if1.rsp0_valid;
   endfunction

   function automatic logic [7:0] rsp_p(input bit n);
      return n ? if1.rsp1_p : if1.rsp0_p;
   endfunction

   task automatic set_rr(input bit n, input logic v);
      if (n) if1.rsp1_ready = v;
      else   if1.rsp0_ready = v;
   endtask

   // One complete transaction on the LAT=1 instance, driven and checked against the model.
   task automatic do_op(input bit v0, input bit v1, input logic [3:0] x0, input logic [3:0] y0,
                        input logic [3:0] x1, input logic [3:0] y1, input int bp);
      bit         w;
      logic [7:0] p;
      w = (v0 && v1) ? ~m_last : v1;
      p = w ? x1 * y1 : x0 * y0;
      if1.req0_valid = v0; if1.req0_a = x0; if1.req0_b = y0;
      if1.req1_valid = v1; if1.req1_a = x1; if1.req1_b = y1;
      #1;
      chk("req0_ready", if1.req0_ready, !w);
      chk("req1_ready", if1.req1_ready, w);
      @(negedge clk);
      if1.req0_valid = 1'b0; if1.req1_valid = 1'b0;
      m_last = w;
      chk("mul_a", mul_a1, w ? x1 : x0);
      chk("mul_b", mul_b1, w ? y1 : y0);
      repeat (LAT1) begin
         chk("busy_wait", busy1, 1);
         chk("rsp_early", if1.rsp0_valid | if1.rsp1_valid, 0);
         @(negedge clk);
      end
      chk("rsp_owner_valid", rsp_v(w), 1);
      chk("rsp_other_valid", rsp_v(!w), 0);
      chk("rsp_p", rsp_p(w), p);
      for (int i = 0; i < bp; i++) begin
         set_rr(!w, 1'($urandom_range(0, 1)));
         @(negedge clk);
         chk("bp_valid", rsp_v(w), 1);
         chk("bp_p", rsp_p(w), p);
         chk("bp_ready", if1.req0_ready | if1.req1_ready, 0);
      end
      set_rr(!w, 1'b0);
      set_rr(w, 1'b1);
      @(negedge clk);
      set_rr(w, 1'b0);
      m_done = (m_done + 1) % 256;
      chk("done_cnt", done1, m_done);
      chk("busy_after", busy1, 0);
      chk("rsp_after", rsp_v(w), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit         v0, v1;
      logic [3:0] r0, r1, r2, r3;
      rst = 1'b1;
      k3 = 0;
      if1.req0_valid = 1'b1; if1.req0_a = 4'd1; if1.req0_b = 4'd1;
      if1.req1_valid = 1'b1; if1.req1_a = 4'd2; if1.req1_b = 4'd2;
      if1.rsp0_ready = 1'b0; if1.rsp1_ready = 1'b0;
      if3.req0_valid = 1'b0; if3.req0_a = 4'd0; if3.req0_b = 4'd0;
      if3.req1_valid = 1'b0; if3.req1_a = 4'd0; if3.req1_b = 4'd0;
      if3.rsp0_ready = 1'b0; if3.rsp1_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {if1.req0_ready, if1.req1_ready}, 0);
      chk("rst_valid", {if1.rsp0_valid, if1.rsp1_valid}, 0);
      chk("rst_mul_a", mul_a1, 0);
      chk("rst_mul_b", mul_b1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      rst = 1'b0;
      if1.req0_valid = 1'b0; if1.req1_valid = 1'b0;
      m_last = 1'b1;
      m_done = 0;
      @(negedge clk);

      do_op(1, 0, 4'd13, 4'd11, 4'd0, 4'd0, 0);
      do_op(1, 1, 4'd3, 4'd5, 4'd15, 4'd15, 0);
      do_op(1, 1, 4'd3, 4'd5, 4'd15, 4'd15, 0);
      for (int i = 0; i < 4; i++) do_op(1, 1, 4'(i), 4'd7, 4'd9, 4'(i + 2), 0);
      do_op(1, 0, 4'd13, 4'd11, 4'd0, 4'd0, 5);

      // LAT=3 instance: accept at T, product valid only at T+3, response at T+4.
      if3.req1_valid = 1'b1; if3.req1_a = 4'd9; if3.req1_b = 4'd7;
      #1;
      chk("l3_ready1", if3.req1_ready, 1);
      @(negedge clk);
      if3.req1_valid = 1'b0;
      chk("l3_mul_a", mul_a3, 9);
      for (int i = 0; i < LAT3; i++) begin
         chk("l3_rsp_early", if3.rsp1_valid, 0);
         @(negedge clk);
      end
      chk("l3_rsp_valid", if3.rsp1_valid, 1);
      chk("l3_rsp_p", if3.rsp1_p, 63);
      chk("l3_rsp0_valid", if3.rsp0_valid, 0);
      if3.rsp1_ready = 1'b1;
      @(negedge clk);
      if3.rsp1_ready = 1'b0;
      chk("l3_done", done3, 1);
      chk("l3_busy", busy3, 0);

      // Reset during WAIT drops the operation.
      if1.req0_valid = 1'b1; if1.req0_a = 4'd6; if1.req0_b = 4'd7;
      @(negedge clk);
      if1.req0_valid = 1'b0;
      chk("mid_busy", busy1, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", {if1.req0_ready, if1.req1_ready}, 0);
      chk("mid_rst_busy", busy1, 0);
      rst = 1'b0;
      m_last = 1'b1;
      m_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_no_rsp", {if1.rsp0_valid, if1.rsp1_valid}, 0);
      end
      chk("mid_done", done1, 0);
      do_op(1, 0, 4'd6, 4'd7, 4'd0, 4'd0, 0);

      for (int i = 0; i < 260; i++) begin
         {v1, v0} = 2'($urandom_range(1, 3));
         r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom); r3 = 4'($urandom);
         do_op(v0, v1, r0, r1, r2, r3, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
